// File: rtl/msdap_out_deser_pkg.sv
// Shared definitions for the MSDAP output deserializer.
//   - deser_state_e : deserializer FSM states
//   - WORD_W_DEF    : default serial word width (ALU accumulator width)
//   - SAT_POS/NEG   : 16-bit PCM saturation limits
//   - sat16()       : PCM extraction helper, present only with OUT_SAT16_EN
package msdap_out_pkg;

  localparam int unsigned WORD_W_DEF = 40;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN
  } deser_state_e;

`ifdef OUT_SAT16_EN
  // Bits [31:16] of a 40-bit result. The value fits in 16 bits only when
  // bits [39:31] are all copies of the sign; otherwise clamp by the sign.
  function automatic logic [15:0] sat16(input logic [39:0] w);
    if ((&w[39:31]) || (~|w[39:31])) begin
      return w[31:16];
    end
    return w[39] ? SAT_NEG : SAT_POS;
  endfunction
`endif

endpackage

// File: rtl/msdap_out_deser_if.sv
// Parallel output handshake of the MSDAP output deserializer.
//   out_valid  : head of the pair FIFO holds a word pair
//   out_ready  : consumer accepts the head this cycle
//   out_data_L : left word at the FIFO head
//   out_data_R : right word at the FIFO head
// master = deserializer side, slave = consumer side.
interface msdap_out_deser_if
  import msdap_out_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
);

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data_L;
  logic [WORD_W-1:0] out_data_R;

  modport master (
    output out_valid,
    output out_data_L,
    output out_data_R,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data_L,
    input  out_data_R,
    output out_ready
  );

endinterface

// File: rtl/msdap_out_deser_pair_fifo.sv
// Generic DEPTH x DW synchronous FIFO for completed L/R word pairs.
//   Sclk, Reset_n : clock, asynchronous active-low reset
//   push/push_data: write request and data
//   pop           : read request (ignored while empty)
//   full, empty   : occupancy flags
//   head          : head entry; while empty, the last popped entry
//   drop          : push rejected this cycle (full, no simultaneous pop)
module msdap_pair_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 80
) (
  input  logic          Sclk,
  input  logic          Reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head,
  output logic          drop
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]   wptr_q;
  logic [PW:0]   rptr_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          pop_ok;
  logic          push_ok;
  logic [PW-1:0] head_idx;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;

  // While empty, point one slot back so the last popped pair stays visible.
  assign head_idx = empty ? (rptr_q[PW-1:0] - PW'(1)) : rptr_q[PW-1:0];
  assign head     = mem_q[head_idx];

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[PW-1:0]] <= push_data;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/msdap_out_deser.sv
// MSDAP serial output deserializer.
// Rebuilds WORD_W-bit left/right pairs from the MSDAP serial stream
// (OutReady qualifies OutputL/OutputR, MSB first), queues them in a
// DEPTH-entry pair FIFO and presents them over a valid/ready interface.
//   Sclk, Reset_n      : clock, asynchronous active-low reset
//   OutReady           : serial frame qualifier
//   OutputL, OutputR   : serial data bits
//   out_if (master)    : out_valid/out_ready/out_data_L/out_data_R
//   frame_err          : sticky, short or long frame seen
//   ovf_err            : sticky, completed pair dropped on a full FIFO
//   err_clr            : synchronous clear of both sticky flags
//   out_pcm_L/R        : saturated 16-bit PCM of the head (OUT_SAT16_EN only)
// Optional feature macro: OUT_SAT16_EN.
module msdap_out_deser
  import msdap_out_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     Sclk,
  input  logic                     Reset_n,
  input  logic                     OutReady,
  input  logic                     OutputL,
  input  logic                     OutputR,
  msdap_out_deser_if.master        out_if,
  input  logic                     err_clr,
  output logic                     frame_err,
  output logic                     ovf_err
`ifdef OUT_SAT16_EN
  ,
  output logic [15:0]              out_pcm_L,
  output logic [15:0]              out_pcm_R
`endif
);

  localparam int unsigned CW = $clog2(WORD_W + 1);

  deser_state_e      state_q;
  logic [CW-1:0]     cnt_q;
  logic [WORD_W-1:0] sr_l_q;
  logic [WORD_W-1:0] sr_r_q;
  logic              push_q;
  logic              armed_q;
  logic              drain_flag_q;
  logic              frame_err_q;
  logic              ovf_err_q;

  logic              frame_set_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_drop;
  logic              fifo_pop;
  logic [2*WORD_W-1:0] fifo_head;
  logic [WORD_W-1:0] head_l;
  logic [WORD_W-1:0] head_r;

  // Errors: OutReady falling mid-word, or the first bit beyond a full word.
  always_comb begin
    frame_set_d = 1'b0;
    if ((state_q == SHIFT) && !OutReady) begin
      frame_set_d = 1'b1;
    end
    if ((state_q == DRAIN) && OutReady && !drain_flag_q) begin
      frame_set_d = 1'b1;
    end
  end

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sr_l_q       <= '0;
      sr_r_q       <= '0;
      push_q       <= 1'b0;
      armed_q      <= 1'b0;
      drain_flag_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      // After reset a frame already in flight is skipped: capture only
      // starts once OutReady has been seen low.
      if (!OutReady) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (OutReady && armed_q) begin
            sr_l_q  <= {sr_l_q[WORD_W-2:0], OutputL};
            sr_r_q  <= {sr_r_q[WORD_W-2:0], OutputR};
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (OutReady) begin
            sr_l_q <= {sr_l_q[WORD_W-2:0], OutputL};
            sr_r_q <= {sr_r_q[WORD_W-2:0], OutputR};
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(WORD_W - 1)) begin
              // Shift registers are frozen in DRAIN, so the pair is still
              // intact when the FIFO write happens on the next edge.
              push_q  <= 1'b1;
              state_q <= DRAIN;
            end
          end else begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (OutReady) begin
            drain_flag_q <= 1'b1;
          end else begin
            drain_flag_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      frame_err_q <= frame_set_d | (frame_err_q & ~err_clr);
      ovf_err_q   <= fifo_drop   | (ovf_err_q & ~err_clr);
    end
  end

  assign fifo_pop = !fifo_empty && out_if.out_ready;

  msdap_pair_fifo #(
    .DEPTH (DEPTH),
    .DW    (2 * WORD_W)
  ) u_fifo (
    .Sclk      (Sclk),
    .Reset_n   (Reset_n),
    .push      (push_q),
    .push_data ({sr_l_q, sr_r_q}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .drop      (fifo_drop)
  );

  assign head_l = fifo_head[2*WORD_W-1:WORD_W];
  assign head_r = fifo_head[WORD_W-1:0];

  assign out_if.out_valid  = !fifo_empty;
  assign out_if.out_data_L = head_l;
  assign out_if.out_data_R = head_r;
  assign frame_err         = frame_err_q;
  assign ovf_err           = ovf_err_q;

`ifdef OUT_SAT16_EN
  assign out_pcm_L = fifo_empty ? '0 : sat16(head_l[39:0]);
  assign out_pcm_R = fifo_empty ? '0 : sat16(head_r[39:0]);
`endif

  // fifo_full is kept for visibility; drop already covers the full case.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
